// File: rtl/booth_mul_ctrl_if.sv
// Control bundle between the radix-2 Booth sequencer and the A/Q/M datapath.
// The slave side is the sequencer; the master side is the decoder/datapath.
interface booth_mul_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             start;
  logic             q_lsb;
  logic             q_m1;
  logic             load_m;
  logic             load_q;
  logic             clear_aq;
  logic             load_a;
  logic             add_sub;
  logic             shift_aq;
  logic             out_a;
  logic             out_q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

  modport master (
    output start, q_lsb, q_m1,
    input  load_m, load_q, clear_aq, load_a, add_sub, shift_aq,
           out_a, out_q, busy, done, iter
  );

  modport slave (
    input  start, q_lsb, q_m1,
    output load_m, load_q, clear_aq, load_a, add_sub, shift_aq,
           out_a, out_q, busy, done, iter
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth multiply sequencer: one ARITH + one SHIFT cycle per iteration,
// fixed latency independent of the operand bits.
module booth_mul_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             reset,
  booth_mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    ARITH  = 3'd3,
    SHIFT  = 3'd4,
    OUT_A  = 3'd5,
    OUT_Q  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    bus.load_m   = 1'b0;
    bus.load_q   = 1'b0;
    bus.clear_aq = 1'b0;
    bus.load_a   = 1'b0;
    bus.add_sub  = 1'b0;
    bus.shift_aq = 1'b0;
    bus.out_a    = 1'b0;
    bus.out_q    = 1'b0;
    bus.done     = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD_M;
      LOAD_M: begin
        bus.load_m = 1'b1;
        state_d    = LOAD_Q;
      end
      LOAD_Q: begin
        bus.load_q   = 1'b1;
        bus.clear_aq = 1'b1;
        iter_d       = '0;
        state_d      = ARITH;
      end
      // Only Mealy state: {Q0,Q-1}=10 subtracts M, 01 adds M, 00/11 leave A alone.
      ARITH: begin
        bus.load_a  = bus.q_lsb ^ bus.q_m1;
        bus.add_sub = bus.q_lsb & ~bus.q_m1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        bus.shift_aq = 1'b1;
        if (iter_q == LAST) begin
          state_d = OUT_A;
        end else begin
          iter_d  = iter_q + CNT_W'(1);
          state_d = ARITH;
        end
      end
      OUT_A: begin
        bus.out_a = 1'b1;
        state_d   = OUT_Q;
      end
      OUT_Q: begin
        bus.out_q = 1'b1;
        bus.done  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.iter = iter_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: a behavioural A/Q/M datapath follows the controls,
// and a scoreboard checks product, done timing and per-op control counts.
module tb_booth_mul_ctrl;
  localparam int W   = 8;
  localparam int LAT = 2 * W + 3;  // done offset from the LOAD_M cycle

  typedef struct {
    logic [15:0] prod;
    int          done_cyc;
    int          adds;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  booth_mul_ctrl_if #(.WIDTH(W)) bus();
  booth_mul_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, c_acc = -100, idle_from = 0, n_done = 0;
  exp_t exp_q[$];

  logic [7:0] opM = '0, opQ = '0;
  logic [8:0] A   = '0;  // guard bit keeps A-M exact for M = -2^(W-1)
  logic [7:0] M   = '0, Q = '0;
  logic       Qm1 = 1'b0;
  int         shifts = 0, adds = 0;

  assign bus.q_lsb = Q[0];
  assign bus.q_m1  = Qm1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int booth_adds(input logic [7:0] q);
    logic [7:0] t;
    t = q ^ {q[6:0], 1'b0};
    return $countones(t);
  endfunction

  function automatic logic [15:0] product(input logic [7:0] m, input logic [7:0] q);
    int mi, qi, p;
    mi = int'($signed(m));
    qi = int'($signed(q));
    p  = mi * qi;
    return p[15:0];
  endfunction

  // Datapath stand-in reacting to the controls
  always @(posedge clk) begin
    if (bus.load_m) begin
      M      <= opM;
      shifts <= 0;
      adds   <= 0;
    end
    if (bus.load_q) Q <= opQ;
    if (bus.clear_aq) begin
      A   <= '0;
      Qm1 <= 1'b0;
    end
    if (bus.load_a) begin
      A    <= bus.add_sub ? A - {M[7], M} : A + {M[7], M};
      adds <= adds + 1;
    end
    if (bus.shift_aq) begin
      {A, Q, Qm1} <= {A[8], A, Q};
      shifts      <= shifts + 1;
    end
  end

  // Reference: an op is accepted when start is seen while the unit is free
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      c_acc     = -100;
      idle_from = cyc + 1;
    end else if (bus.start && cyc >= idle_from) begin
      c_acc      = cyc;
      idle_from  = cyc + LAT + 2;
      e.prod     = product(opM, opQ);
      e.done_cyc = cyc + LAT;
      e.adds     = booth_adds(opQ);
      exp_q.push_back(e);
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [5:0] v;
    exp_t       e;
    if (!reset) begin
      v = {bus.load_m, bus.load_q, bus.load_a, bus.shift_aq, bus.out_a, bus.out_q};
      chk("onehot", 32'($countones(v) <= 1), 1);
      chk("done_implies_outq", 32'(!bus.done || bus.out_q), 1);
      chk("clear_with_loadq", 32'(bus.clear_aq), 32'(bus.load_q));
      chk("iter_range", 32'(bus.iter <= 3'(W - 1)), 1);
      chk("busy", 32'(bus.busy), 32'(cyc >= c_acc && cyc <= c_acc + LAT));
      chk("load_m_timing", 32'(bus.load_m), 32'(cyc == c_acc));
      if (bus.done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("product", 32'({A[7:0], Q}), 32'(e.prod));
          chk("done_cycle", cyc, e.done_cyc);
          chk("shift_count", shifts, W);
          chk("addsub_count", adds, e.adds);
        end
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(t < 60), 1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    opM = m; opQ = q; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, t;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.load_m, bus.load_q, bus.clear_aq, bus.load_a, bus.add_sub,
                              bus.shift_aq, bus.out_a, bus.out_q, bus.busy, bus.done}), 0);
    chk("reset_iter", 32'(bus.iter), 0);
    reset = 1'b0;

    run_op(8'h37, 8'h00);  // 00 pattern every iteration: no adder loads
    run_op(8'h05, 8'hFD);  // 5 * -3
    run_op(8'h80, 8'h80);  // -128 * -128
    run_op(8'h7F, 8'h80);
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // start held high: ignored while busy, restarts after one IDLE cycle
    @(negedge clk);
    opM = 8'h07; opQ = 8'hF7; bus.start = 1'b1;
    d0 = n_done;
    repeat (50) @(negedge clk);
    bus.start = 1'b0;
    chk("held_start_dones", n_done - d0, 2);
    wait_done();

    // async reset in the middle of SHIFT at iter 4
    @(negedge clk);
    opM = 8'h5A; opQ = 8'hC3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (!(bus.shift_aq && bus.iter == 3'd4) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("reach_shift_iter4", 32'(t < 40), 1);
    #2 reset = 1'b1;
    #1;
    chk("midop_reset_outputs", 32'({bus.load_m, bus.load_q, bus.clear_aq, bus.load_a, bus.add_sub,
                                    bus.shift_aq, bus.out_a, bus.out_q, bus.busy, bus.done}), 0);
    chk("midop_reset_iter", 32'(bus.iter), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_restart_after_reset", 32'(bus.busy), 0);
    run_op(8'hE9, 8'h1B);
    run_op(8'($urandom), 8'($urandom));

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
